// File: rtl/multimac_if.sv
// Bundle of control, load and result signals for multimac_core.
// Latency: none, wires only.
// Backpressure: none; load/start are strobes that the core accepts only while idle.
//
// master: drives clear/mode/load_*/start and observes busy/done/result/found/overflow.
// slave : the core side.
interface multimac_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 4,
    parameter int ACC_W  = 16
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              clear;
    logic [1:0]        mode;
    logic              load_valid;
    logic [IDX_W-1:0]  load_index;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              found;
    logic              overflow;

    modport master (
        output clear, mode, load_valid, load_index, load_data, start,
        input  busy, done, result, found, overflow
    );

    modport slave (
        input  clear, mode, load_valid, load_index, load_data, start,
        output busy, done, result, found, overflow
    );
endinterface

// File: rtl/multimac_core.sv
// Cell array with MIN / MAX index search, MADD (second-order prefix accumulation) and COUNT scans.
// Latency: MIN/MAX stop at the first hit (hit position + 1 cycles), MADD/COUNT take DEPTH cycles, then one DONE cycle.
// Backpressure: none; load_valid/start are honoured only in IDLE and silently ignored otherwise.
//
// Ports: clk, rst (async, active-high) plus the multimac_if slave modport.
// DEPTH must be a power of two and at least 4; ACC_W must be at least DATA_W+2.
module multimac_core #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 4,
    parameter int ACC_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    multimac_if.slave   bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CELL_W = DATA_W + 2;

    localparam logic [1:0] M_MIN   = 2'b00;
    localparam logic [1:0] M_MAX   = 2'b01;
    localparam logic [1:0] M_MADD  = 2'b10;
    localparam logic [1:0] M_COUNT = 2'b11;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [CELL_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]         idx_q;
    logic [1:0]               mode_q;
    logic signed [ACC_W-1:0]  delta_q, count_q, total_q;
    logic [ACC_W-1:0]         result_q;
    logic                     found_q, overflow_q;

    logic signed [CELL_W-1:0] cur;
    logic                     hit, last, stop;
    logic signed [CELL_W-1:0] ld_ext;
    logic signed [ACC_W-1:0]  delta_n, count_n, total_n, final_n;
    logic [ACC_W-1:0]         cnt_inc;
    logic                     ov_step, ov_final;

    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b,
                                     input logic signed [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    assign cur    = mem[idx_q];
    assign hit    = (cur != '0);
    // MIN walks upward, every other mode walks downward.
    assign last   = (mode_q == M_MIN) ? (idx_q == IDX_W'(DEPTH - 1)) : (idx_q == '0);
    // MIN/MAX (mode_q[1] == 0) terminate early on the first nonzero cell.
    assign stop   = (!mode_q[1] && hit) || last;
    assign ld_ext = $signed({2'b00, bus.load_data});

    // All three MADD terms advance from the previous-cycle values.
    assign delta_n  = delta_q + ACC_W'(cur);
    assign count_n  = count_q + delta_q;
    assign total_n  = total_q + count_q;
    assign final_n  = total_n + count_n;
    assign ov_step  = add_ovf(count_q, delta_q, count_n) || add_ovf(total_q, count_q, total_n);
    assign ov_final = add_ovf(total_n, count_n, final_n);
    assign cnt_inc  = count_q + {{(ACC_W-1){1'b0}}, hit};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && !bus.load_valid) state_d = SCAN;
            SCAN:    if (stop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.clear) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            mode_q     <= M_MIN;
            delta_q    <= '0;
            count_q    <= '0;
            total_q    <= '0;
            result_q   <= '0;
            found_q    <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            if (bus.clear) begin
                // Results stay put so software can still read the last completed run.
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (state_q == IDLE) begin
                if (bus.load_valid) begin
                    if (bus.mode == M_MADD) begin
                        mem[bus.load_index] <= mem[bus.load_index] + ld_ext;
                        if (bus.load_index != '0)
                            mem[bus.load_index - IDX_W'(1)] <= mem[bus.load_index - IDX_W'(1)] - ld_ext;
                    end else begin
                        mem[bus.load_index] <= CELL_W'(1);
                    end
                end else if (bus.start) begin
                    mode_q     <= bus.mode;
                    idx_q      <= (bus.mode == M_MIN) ? '0 : '1;
                    delta_q    <= '0;
                    count_q    <= '0;
                    total_q    <= '0;
                    found_q    <= 1'b0;
                    overflow_q <= 1'b0;
                end
            end else if (state_q == SCAN) begin
                idx_q <= (mode_q == M_MIN) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
                case (mode_q)
                    M_MIN, M_MAX: begin
                        if (hit) begin
                            result_q <= ACC_W'(idx_q);
                            found_q  <= 1'b1;
                        end else if (last) begin
                            result_q <= '0;
                        end
                    end
                    M_MADD: begin
                        delta_q <= delta_n;
                        count_q <= count_n;
                        total_q <= total_n;
                        if (ov_step || (last && ov_final)) overflow_q <= 1'b1;
                        if (last) result_q <= final_n;
                    end
                    M_COUNT: begin
                        count_q <= cnt_inc;
                        if (last) result_q <= cnt_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy     = (state_q == SCAN);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.found    = found_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_multimac_core.sv
module tb_multimac_core;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 4;
    localparam int ACC_W  = 12;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CELL_W = DATA_W + 2;

    localparam logic [1:0] M_MIN = 2'b00, M_MAX = 2'b01, M_MADD = 2'b10, M_COUNT = 2'b11;

    typedef struct {
        logic [ACC_W-1:0] res;
        bit               found;
        bit               ov;
        int               cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   mem_m [DEPTH];
    exp_t sb_q [$];
    int   busy_cnt = 0;

    multimac_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    multimac_core #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wrap_cell(input int x);
        int m = 1 << CELL_W;
        int v = x & (m - 1);
        if (v >= m / 2) v -= m;
        return v;
    endfunction

    function automatic longint wrap_acc(input longint x);
        longint m = longint'(1) << ACC_W;
        longint v = x & (m - 1);
        if (v >= m / 2) v -= m;
        return v;
    endfunction

    function automatic bit oor(input longint x);
        longint lim = longint'(1) << (ACC_W - 1);
        return (x >= lim) || (x < -lim);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    endfunction

    function automatic void model_load(input logic [1:0] m, input int idx, input int d);
        if (m == M_MADD) begin
            mem_m[idx] = wrap_cell(mem_m[idx] + d);
            if (idx > 0) mem_m[idx-1] = wrap_cell(mem_m[idx-1] - d);
        end else begin
            mem_m[idx] = 1;
        end
    endfunction

    function automatic exp_t model_run(input logic [1:0] m);
        exp_t   e;
        longint d = 0, c = 0, t = 0, r;
        logic [63:0] rv;
        e.res = '0; e.found = 0; e.ov = 0; e.cycles = DEPTH;
        case (m)
            M_MIN: begin
                for (int i = 0; i < DEPTH; i++)
                    if (!e.found && mem_m[i] != 0) begin
                        e.found = 1; e.res = ACC_W'(i); e.cycles = i + 1;
                    end
            end
            M_MAX: begin
                for (int i = DEPTH - 1; i >= 0; i--)
                    if (!e.found && mem_m[i] != 0) begin
                        e.found = 1; e.res = ACC_W'(i); e.cycles = DEPTH - i;
                    end
            end
            M_MADD: begin
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    longint nd = d + mem_m[i];
                    longint nc = c + d;
                    longint nt = t + c;
                    if (oor(nc) || oor(nt)) e.ov = 1;
                    d = wrap_acc(nd); c = wrap_acc(nc); t = wrap_acc(nt);
                end
                r = t + c;
                if (oor(r)) e.ov = 1;
                rv = r;
                e.res = rv[ACC_W-1:0];
            end
            default: begin
                int n = 0;
                for (int i = 0; i < DEPTH; i++) if (mem_m[i] != 0) n++;
                e.res = ACC_W'(n);
            end
        endcase
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else if (bus.done) begin
            if (sb_q.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL unexpected_done: done=1 with no run outstanding at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("result",     bus.result,   e.res);
                check("found",      bus.found,    e.found);
                check("overflow",   bus.overflow, e.ov);
                check("busy_cycles", busy_cnt,    e.cycles);
            end
            busy_cnt = 0;
        end else if (bus.busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_load(input logic [1:0] m, input int idx, input int d);
        logic [31:0] iv = idx, dv = d;
        bus.mode = m; bus.load_valid = 1'b1;
        bus.load_index = iv[IDX_W-1:0]; bus.load_data = dv[DATA_W-1:0];
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        model_load(m, idx, d);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        model_clear();
    endtask

    task automatic do_run(input logic [1:0] m, input bit noise);
        bit seen = 0;
        sb_q.push_back(model_run(m));
        bus.mode = m; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < DEPTH + 8; c++) begin
            if (noise) begin
                bus.start = 1'($urandom); bus.load_valid = 1'($urandom);
                bus.mode = 2'($urandom); bus.load_index = IDX_W'($urandom);
                bus.load_data = DATA_W'($urandom);
            end
            @(negedge clk);
            if (bus.done) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        if (!seen) begin
            n_total++; n_bad++;
            $display("FAIL run_timeout: no done within %0d cycles", DEPTH + 8);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.load_valid = 1'b0;
    endtask

    initial begin
        bus.clear = 0; bus.mode = 0; bus.load_valid = 0; bus.load_index = 0;
        bus.load_data = 0; bus.start = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_found", bus.found, 0);
        check("rst_overflow", bus.overflow, 0);
        @(posedge clk); #1;

        // MIN / MAX with hits at 5 and 9, then MAX over empty memory
        do_load(M_MIN, 5, 0);
        do_load(M_MIN, 9, 0);
        do_run(M_MIN, 0);
        do_run(M_MAX, 0);
        do_clear();
        do_run(M_MAX, 0);

        // MADD single load
        do_load(M_MADD, 3, 2);
        do_run(M_MADD, 0);

        // COUNT with a repeated index and both ends
        do_clear();
        do_load(M_COUNT, 0, 0); do_load(M_COUNT, 0, 0);
        do_load(M_COUNT, 7, 0); do_load(M_COUNT, 15, 0);
        do_run(M_COUNT, 0);

        // MADD at index 0 must not disturb the top cell
        do_clear();
        do_load(M_MADD, 0, 3);
        do_run(M_COUNT, 0);
        do_run(M_MAX, 0);
        do_run(M_MADD, 0);

        // MADD overflow in the accumulators
        do_clear();
        do_load(M_MADD, 15, 15); do_load(M_MADD, 15, 15); do_load(M_MADD, 15, 1);
        do_run(M_MADD, 0);

        // load and start together: load wins, no run
        do_clear();
        bus.mode = M_COUNT; bus.load_valid = 1'b1; bus.start = 1'b1;
        bus.load_index = IDX_W'(11);
        @(posedge clk); #1;
        bus.load_valid = 1'b0; bus.start = 1'b0;
        model_load(M_COUNT, 11, 0);
        check("load_start_busy", bus.busy, 0);
        @(posedge clk); #1;
        check("load_start_busy2", bus.busy, 0);
        do_run(M_MIN, 0);

        // start/load/mode noise during a scan
        do_load(M_MADD, 6, 5);
        do_run(M_MADD, 1);
        do_run(M_COUNT, 1);

        // async reset at scan cycle 4 of a MADD run that follows a nonzero result
        do_clear();
        do_load(M_MADD, 3, 2);
        do_run(M_MADD, 0);
        bus.mode = M_MADD; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_result", bus.result, 0);
        check("arst_found", bus.found, 0);
        check("arst_overflow", bus.overflow, 0);
        model_clear();
        @(posedge clk); #1 rst = 1'b0;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        do_run(M_COUNT, 0);

        // clear mid-scan after a MIN run that found something
        do_load(M_MIN, 2, 0);
        do_load(M_MIN, 14, 0);
        do_run(M_MIN, 0);
        bus.mode = M_COUNT; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        model_clear();
        check("clr_busy", bus.busy, 0);
        check("clr_done", bus.done, 0);
        check("clr_found", bus.found, 0);
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        do_run(M_COUNT, 0);
        do_run(M_MAX, 0);

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            int nl;
            if ($urandom_range(0, 5) == 0) do_clear();
            nl = $urandom_range(0, 6);
            for (int k = 0; k < nl; k++)
                do_load(2'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, (1 << DATA_W) - 1));
            do_run(2'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
